// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, FSM states, instruction fields.
package cpu_pkg;

    // Opcodes, bits [5:0] of the instruction word
    localparam logic [5:0] OpNop   = 6'd0;
    localparam logic [5:0] OpAdd   = 6'd1;
    localparam logic [5:0] OpSub   = 6'd2;
    localparam logic [5:0] OpAnd   = 6'd3;
    localparam logic [5:0] OpOr    = 6'd4;
    localparam logic [5:0] OpXor   = 6'd5;
    localparam logic [5:0] OpLdi   = 6'd6;
    localparam logic [5:0] OpStore = 6'd7;
    localparam logic [5:0] OpLoad  = 6'd8;
    localparam logic [5:0] OpJmp   = 6'd9;
    localparam logic [5:0] OpBrf   = 6'd10;
    localparam logic [5:0] OpCmplt = 6'd11;
    localparam logic [5:0] OpHalt  = 6'd63;

    // Core states; encoding is fixed so it can be observed in waveforms
    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StExec  = 2'd1,
        StMem   = 2'd2,
        StHalt  = 2'd3
    } state_e;

    // Instruction field positions
    localparam int unsigned OpLsb   = 0;
    localparam int unsigned OpW     = 6;
    localparam int unsigned RaLsb   = 6;
    localparam int unsigned RbLsb   = 9;
    localparam int unsigned RdLsb   = 12;
    localparam int unsigned RegIdxW = 3;
    localparam int unsigned HlBit   = 15;
    localparam int unsigned ImmLsb  = 16;
    localparam int unsigned ImmW    = 16;
    localparam int unsigned NumRegs = 8;

    // True for every opcode the core implements; anything else raises illegal
    function automatic logic op_is_defined(logic [5:0] op);
        return (op <= OpCmplt) || (op == OpHalt);
    endfunction

endpackage

// File: rtl/cpu_multicycle_if.sv
// Single request/ready memory port shared by instruction fetch and data access.
interface cpu_multicycle_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) ();

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  rdata,
        input  ready
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output rdata,
        output ready
    );

endinterface

// File: rtl/cpu_alu.sv
// Combinational execute unit: computes the register result and zero flag for register ops.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [5:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [15:0]       imm,
    input  logic              hl,
    input  logic [DATA_W-1:0] old_rd,
    output logic [DATA_W-1:0] result,
    output logic              flag_out,
    output logic              writes_rd,
    output logic              writes_flag
);

    logic [DATA_W-1:0] ldi_mask;
    logic [DATA_W-1:0] ldi_val;
    logic              lt;

    // Result selection; LDI merges the immediate into the selected half-word of old_rd
    always_comb begin
        result      = '0;
        flag_out    = 1'b0;
        writes_rd   = 1'b0;
        writes_flag = 1'b0;
        lt          = (a < b);
        // With DATA_W = 16 the upper half-word does not exist, so hl = 1 leaves rD unchanged
        ldi_mask    = hl ? DATA_W'(32'hFFFF_0000) : DATA_W'(32'h0000_FFFF);
        ldi_val     = hl ? DATA_W'({imm, 16'h0000}) : DATA_W'(imm);
        case (op)
            OpAdd: begin
                result      = a + b;
                writes_rd   = 1'b1;
                writes_flag = 1'b1;
                flag_out    = (result == '0);
            end
            OpSub: begin
                result      = a - b;
                writes_rd   = 1'b1;
                writes_flag = 1'b1;
                flag_out    = (result == '0);
            end
            OpAnd: begin
                result      = a & b;
                writes_rd   = 1'b1;
                writes_flag = 1'b1;
                flag_out    = (result == '0);
            end
            OpOr: begin
                result      = a | b;
                writes_rd   = 1'b1;
                writes_flag = 1'b1;
                flag_out    = (result == '0);
            end
            OpXor: begin
                result      = a ^ b;
                writes_rd   = 1'b1;
                writes_flag = 1'b1;
                flag_out    = (result == '0);
            end
            OpLdi: begin
                result    = (old_rd & ~ldi_mask) | (ldi_val & ldi_mask);
                writes_rd = 1'b1;
            end
            OpCmplt: begin
                result      = DATA_W'(lt);
                writes_rd   = 1'b1;
                writes_flag = 1'b1;
                flag_out    = lt;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_multicycle.sv
// Multi-cycle core: FETCH/EXEC/MEM/HALT sequencer, PC, instruction register, GPRs and flags.
module cpu_multicycle
    import cpu_pkg::*;
#(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic       clock,
    input  logic       reset,
    cpu_multicycle_if.master mem,
    output logic       halted,
    output logic       illegal
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d, pc_inc;
    logic [31:0]         instr_q, instr_d;
    logic [DATA_W-1:0]   gpr_q [NumRegs];
    logic [NumRegs-1:0]  flag_q;
    logic                illegal_q, illegal_d;

    // Decoded instruction fields
    logic [OpW-1:0]      op;
    logic [RegIdxW-1:0]  ra_idx, rb_idx, rd_idx;
    logic                hl;
    logic [ImmW-1:0]     imm;
    logic [DATA_W-1:0]   ra_val, rb_val, rd_val;
    logic [ADDR_W-1:0]   ra_addr;

    // Register-file write port
    logic                rd_we;
    logic [DATA_W-1:0]   rd_data;
    logic                flag_we;
    logic                flag_val;

    // ALU outputs
    logic [DATA_W-1:0]   alu_result;
    logic                alu_flag;
    logic                alu_writes_rd;
    logic                alu_writes_flag;

    assign op      = instr_q[OpLsb +: OpW];
    assign ra_idx  = instr_q[RaLsb +: RegIdxW];
    assign rb_idx  = instr_q[RbLsb +: RegIdxW];
    assign rd_idx  = instr_q[RdLsb +: RegIdxW];
    assign hl      = instr_q[HlBit];
    assign imm     = instr_q[ImmLsb +: ImmW];
    assign ra_val  = gpr_q[ra_idx];
    assign rb_val  = gpr_q[rb_idx];
    assign rd_val  = gpr_q[rd_idx];
    assign ra_addr = ADDR_W'(ra_val);
    assign pc_inc  = pc_q + ADDR_W'(1);

    cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op          (op),
        .a           (ra_val),
        .b           (rb_val),
        .imm         (imm),
        .hl          (hl),
        .old_rd      (rd_val),
        .result      (alu_result),
        .flag_out    (alu_flag),
        .writes_rd   (alu_writes_rd),
        .writes_flag (alu_writes_flag)
    );

    // Bus drive; sources are registers, so address/we/wdata hold steady while waiting for ready
    always_comb begin
        mem.req   = reset && ((state_q == StFetch) || (state_q == StMem));
        mem.we    = (state_q == StMem) && (op == OpStore);
        mem.addr  = (state_q == StMem) ? ra_addr : pc_q;
        mem.wdata = rb_val;
    end

    assign halted  = (state_q == StHalt);
    assign illegal = illegal_q;

    // Next-state, PC update and register writes for each phase
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        illegal_d = illegal_q;
        rd_we     = 1'b0;
        rd_data   = '0;
        flag_we   = 1'b0;
        flag_val  = 1'b0;
        unique case (state_q)
            StFetch: begin
                if (mem.ready) begin
                    instr_d = 32'(mem.rdata);
                    state_d = StExec;
                end
            end
            StExec: begin
                case (op)
                    OpLoad, OpStore: begin
                        state_d = StMem;
                    end
                    OpJmp: begin
                        pc_d    = ra_addr;
                        state_d = StFetch;
                    end
                    OpBrf: begin
                        pc_d    = flag_q[ra_idx] ? ADDR_W'(imm) : pc_inc;
                        state_d = StFetch;
                    end
                    OpHalt: begin
                        state_d = StHalt;
                    end
                    default: begin
                        // Register ops, NOP and undefined opcodes all fall through to pc+1
                        rd_we    = alu_writes_rd;
                        rd_data  = alu_result;
                        flag_we  = alu_writes_flag;
                        flag_val = alu_flag;
                        pc_d     = pc_inc;
                        state_d  = StFetch;
                        if (!op_is_defined(op)) begin
                            illegal_d = 1'b1;
                        end
                    end
                endcase
            end
            StMem: begin
                if (mem.ready) begin
                    if (op == OpLoad) begin
                        rd_we    = 1'b1;
                        rd_data  = mem.rdata;
                        flag_we  = 1'b1;
                        flag_val = (mem.rdata == '0);
                    end
                    pc_d    = pc_inc;
                    state_d = StFetch;
                end
            end
            StHalt: ;
            default: state_d = StFetch;
        endcase
    end

    // State, PC, instruction and register-file update with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            flag_q    <= '0;
            illegal_q <= 1'b0;
            for (int i = 0; i < NumRegs; i++) begin
                gpr_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            illegal_q <= illegal_d;
            if (rd_we) begin
                gpr_q[rd_idx] <= rd_data;
            end
            if (flag_we) begin
                flag_q[rd_idx] <= flag_val;
            end
        end
    end

endmodule

// File: tb/tb_cpu_multicycle.sv
// Bench for cpu_multicycle: memory responder plus an instruction-level reference model.
module tb_cpu_multicycle;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic halted;
    logic illegal;

    cpu_multicycle_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    cpu_multicycle #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .RESET_PC ('0)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .mem     (bus),
        .halted  (halted),
        .illegal (illegal)
    );

    always #5 clock = ~clock;

    logic [31:0] mem [256];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input int op, input int rd, input int ra, input int rb,
                                        input int hl, input int imm);
        logic [31:0] w;
        w = {16'(imm), 1'(hl), 3'(rd), 3'(rb), 3'(ra), 6'(op)};
        return w;
    endfunction

    // Architectural model: registers, flags, pc and which bus access is due next
    logic [31:0] m_reg [8];
    logic        m_flag [8];
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_illegal;
    int          m_phase;  // 0 = expect fetch, 1 = expect data access, 2 = halted

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_reg[i]  = '0;
            m_flag[i] = 1'b0;
        end
        m_pc      = '0;
        m_instr   = '0;
        m_illegal = 1'b0;
        m_phase   = 0;
    endtask

    task automatic set_rd(input int rd, input logic [31:0] v, input logic f);
        m_reg[rd]  = v;
        m_flag[rd] = f;
    endtask

    task automatic model_exec();
        int op, ra, rb, rd;
        logic hl;
        logic [15:0] imm;
        logic [31:0] a, b, r;
        op  = int'(m_instr[5:0]);
        ra  = int'(m_instr[8:6]);
        rb  = int'(m_instr[11:9]);
        rd  = int'(m_instr[14:12]);
        hl  = m_instr[15];
        imm = m_instr[31:16];
        a   = m_reg[ra];
        b   = m_reg[rb];
        case (op)
            0: m_pc = m_pc + 1;
            1: begin r = a + b; set_rd(rd, r, r == 0); m_pc = m_pc + 1; end
            2: begin r = a - b; set_rd(rd, r, r == 0); m_pc = m_pc + 1; end
            3: begin r = a & b; set_rd(rd, r, r == 0); m_pc = m_pc + 1; end
            4: begin r = a | b; set_rd(rd, r, r == 0); m_pc = m_pc + 1; end
            5: begin r = a ^ b; set_rd(rd, r, r == 0); m_pc = m_pc + 1; end
            6: begin
                r = m_reg[rd];
                if (hl) r[31:16] = imm;
                else    r[15:0]  = imm;
                m_reg[rd] = r;
                m_pc = m_pc + 1;
            end
            7, 8: m_phase = 1;
            9: m_pc = a;
            10: m_pc = m_flag[ra] ? {16'h0000, imm} : m_pc + 1;
            11: begin set_rd(rd, (a < b) ? 32'd1 : 32'd0, a < b); m_pc = m_pc + 1; end
            63: m_phase = 2;
            default: begin m_illegal = 1'b1; m_pc = m_pc + 1; end
        endcase
    endtask

    int          writes_to_5 = 0;
    bit          fetched [256];

    // Called on the cycle a request is acknowledged; compares it to what the model expects
    task automatic commit();
        int op, ra, rb, rd;
        logic [7:0] a8;
        a8 = bus.addr[7:0];
        if (m_phase == 2) begin
            check("req_while_halted", bus.req, 0);
        end else if (m_phase == 0) begin
            check("fetch_we", bus.we, 0);
            check("fetch_addr", bus.addr, m_pc);
            check("illegal_flag", illegal, m_illegal);
            check("halted_flag", halted, 0);
            fetched[a8] = 1'b1;
            m_instr = mem[a8];
            model_exec();
        end else begin
            op = int'(m_instr[5:0]);
            ra = int'(m_instr[8:6]);
            rb = int'(m_instr[11:9]);
            rd = int'(m_instr[14:12]);
            check("data_we", bus.we, (op == 7) ? 1 : 0);
            check("data_addr", bus.addr, m_reg[ra]);
            if (op == 7) begin
                check("store_data", bus.wdata, m_reg[rb]);
                mem[a8] = bus.wdata;
                if (bus.addr == 32'd5) writes_to_5++;
            end else begin
                set_rd(rd, mem[a8], mem[a8] == 0);
            end
            m_pc    = m_pc + 1;
            m_phase = 0;
        end
    endtask

    // Memory responder and compare process; acts on the falling edge, away from the DUT edge
    logic        busy = 1'b0;
    int          waits = 0;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_we;
    int          stall_n = 0;
    logic [31:0] stall_addr = '0;
    logic        stall_we = 1'b0;

    always @(negedge clock) begin
        if (!reset) begin
            model_reset();
            busy      = 1'b0;
            bus.ready = 1'b0;
        end else if (!bus.req) begin
            busy      = 1'b0;
            bus.ready = 1'b0;
        end else begin
            if (!busy || bus.ready) begin
                busy      = 1'b1;
                cap_addr  = bus.addr;
                cap_we    = bus.we;
                cap_wdata = bus.wdata;
                waits     = 0;
                if (stall_n > 0 && bus.addr == stall_addr && bus.we == stall_we) begin
                    waits   = stall_n;
                    stall_n = 0;
                end else if (!bus.we && bus.addr[1:0] == 2'd3) begin
                    waits = 1;
                end
            end else begin
                check("addr_stable", bus.addr, cap_addr);
                check("we_stable", bus.we, cap_we);
                if (cap_we) check("wdata_stable", bus.wdata, cap_wdata);
            end
            if (waits > 0) begin
                bus.ready = 1'b0;
                waits--;
            end else begin
                bus.ready = 1'b1;
                bus.rdata = mem[bus.addr[7:0]];
                commit();
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_halt(input int bound);
        for (int i = 0; i < bound && !halted; i++) tick();
        check("halt_reached", halted, 1);
    endtask

    task automatic load_prog1();
        for (int i = 0; i < 256; i++) mem[i] = enc(63, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) mem[i] = enc(7, 0, 0, i, 0, 0);  // STORE [r0] <= ri
        mem[8]    = enc(6, 1, 0, 0, 0, 16'h0005);                     // LDI r1 lo 5
        mem[9]    = enc(6, 2, 0, 0, 0, 16'h0003);                     // LDI r2 lo 3
        mem[10]   = enc(2, 3, 1, 2, 0, 0);                            // SUB r3 = r1-r2
        mem[11]   = enc(2, 4, 2, 2, 0, 0);                            // SUB r4 = r2-r2
        mem[12]   = enc(7, 0, 1, 3, 0, 0);                            // STORE [r1] <= r3
        mem[13]   = enc(8, 6, 1, 0, 0, 0);                            // LOAD r6 <= [r1]
        mem[14]   = enc(11, 5, 2, 1, 0, 0);                           // CMPLT r5 = r2<r1
        mem[15]   = enc(10, 0, 5, 0, 0, 16'h0040);                    // BRF r5 -> 0x40
        mem[8'h40] = enc(11, 5, 1, 2, 0, 0);                          // CMPLT r5 = r1<r2
        mem[8'h41] = enc(10, 0, 5, 0, 0, 16'h0010);                   // BRF not taken
        mem[8'h42] = enc(1, 0, 1, 2, 0, 0);                           // ADD r0 = r1+r2
        mem[8'h43] = enc(3, 7, 1, 2, 0, 0);                           // AND r7
        mem[8'h44] = enc(4, 3, 3, 1, 0, 0);                           // OR r3 = r3|r1
        mem[8'h45] = enc(5, 4, 1, 1, 0, 0);                           // XOR r4 = r1^r1
        mem[8'h46] = enc(6, 6, 0, 0, 1, 16'hABCD);                    // LDI r6 hi
        mem[8'h47] = enc(6, 7, 0, 0, 0, 16'h0060);                    // LDI r7 lo 0x60
        for (int i = 0; i < 8; i++) mem[8'h48 + i] = enc(7, 0, 4, i, 0, 0);
        mem[8'h50] = enc(9, 0, 7, 0, 0, 0);                           // JMP r7
        mem[8'h60] = enc(6'h2A, 0, 0, 0, 0, 0);                       // undefined opcode
        mem[8'h61] = enc(63, 0, 0, 0, 0, 0);                          // HALT
    endtask

    task automatic load_prog2();
        for (int i = 0; i < 256; i++) mem[i] = enc(63, 0, 0, 0, 0, 0);
        mem[0] = enc(0, 0, 0, 0, 0, 0);                               // NOP
        for (int i = 0; i < 8; i++) mem[1 + i] = enc(7, 0, 0, i, 0, 0);
        mem[9]     = enc(6, 1, 0, 0, 0, 16'h0030);                    // LDI r1 lo 0x30
        mem[10]    = enc(8, 2, 1, 0, 0, 0);                           // LOAD r2 <= [r1]
        mem[11]    = enc(7, 0, 1, 2, 0, 0);                           // STORE [r1] <= r2
        mem[12]    = enc(63, 0, 0, 0, 0, 0);
        mem[8'h30] = 32'h0000_1234;
    endtask

    initial begin
        bit found;
        bus.ready = 1'b0;
        bus.rdata = '0;
        model_reset();
        load_prog1();
        stall_addr = 32'd5;
        stall_we   = 1'b1;
        stall_n    = 4;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            check("req_in_reset", bus.req, 0);
        end
        check("halted_in_reset", halted, 0);
        check("illegal_in_reset", illegal, 0);
        reset = 1'b1;
        #1;
        check("req_after_release", bus.req, 1);
        check("addr_after_release", bus.addr, 0);

        wait_halt(400);
        check("illegal_after_2a", illegal, 1);
        check("model_halted", m_phase, 2);
        check("r0", m_reg[0], 32'd8);
        check("r1", m_reg[1], 32'd5);
        check("r2", m_reg[2], 32'd3);
        check("r3", m_reg[3], 32'd7);
        check("r4", m_reg[4], 32'd0);
        check("r5", m_reg[5], 32'd0);
        check("r6", m_reg[6], 32'hABCD_0002);
        check("r7", m_reg[7], 32'h0000_0060);
        check("flag4", m_flag[4], 1);
        check("flag6", m_flag[6], 0);
        check("mem5", mem[5], 32'd2);
        check("writes_to_5", writes_to_5, 1);
        check("fetched_0x40", fetched[8'h40], 1);
        check("fetched_0x42", fetched[8'h42], 1);
        check("fetched_16", fetched[16], 0);
        check("fetched_0x51", fetched[8'h51], 0);

        for (int i = 0; i < 20; i++) begin
            tick();
            check("req_while_halted", bus.req, 0);
            check("halted_hold", halted, 1);
        end

        reset = 1'b0;
        tick();
        check("halted_cleared", halted, 0);
        check("illegal_cleared", illegal, 0);
        check("req_gated_reset", bus.req, 0);
        load_prog2();
        stall_addr = 32'h30;
        stall_we   = 1'b0;
        stall_n    = 1000;
        tick();
        reset = 1'b1;

        // Abort a LOAD that is stuck in wait states
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (bus.req && !bus.we && bus.addr == 32'h30) found = 1'b1;
        end
        check("load_request_seen", found, 1);
        tick();
        tick();
        check("load_still_pending", bus.req, 1);
        reset = 1'b0;
        #1;
        check("req_gated_abort", bus.req, 0);
        tick();
        check("req_low_after_abort", bus.req, 0);
        reset = 1'b1;
        #1;
        check("refetch_req", bus.req, 1);
        check("refetch_addr", bus.addr, 0);

        wait_halt(400);
        check("illegal_prog2", illegal, 0);
        check("p2_r1", m_reg[1], 32'h30);
        check("p2_r2", m_reg[2], 32'h1234);
        check("p2_mem30", mem[8'h30], 32'h1234);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
